pipeline_mem_arbiter: RTL and testbench
=======================================

# pipeline_mem_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch (IF) port and data-memory (DM, lw/sw) port. Sits between the pipeline CPU stages and the memory, sequences one memory transaction at a time, and gives DM priority with a starvation guard for IF. The pipeline stalls a stage while its `*_req` is high and `*_ready` is low.

## Interface
- `ADDR_WIDTH`, 32, byte address width on all ports
- `DATA_WIDTH`, 32, data word width
- `STARVE_LIMIT`, 4, consecutive DM grants allowed while IF waits (≥1)
- `clock  in  1  sole clock, rising edge`
- `reset  in  1  asynchronous, active-low; 0 = in reset`
- `if_req  in  1  fetch request, level, held until if_ready`
- `if_addr  in  ADDR_WIDTH  fetch address, stable while if_req`
- `if_rdata  out  DATA_WIDTH  fetched word, valid when if_ready`
- `if_ready  out  1  one-cycle completion pulse for IF`
- `dm_req  in  1  data request, level, held until dm_ready`
- `dm_we  in  1  1 = store (sw), 0 = load (lw)`
- `dm_addr  in  ADDR_WIDTH  data address`
- `dm_wdata  in  DATA_WIDTH  store data`
- `dm_rdata  out  DATA_WIDTH  load data, valid when dm_ready`
- `dm_ready  out  1  one-cycle completion pulse for DM`
- `mem_req  out  1  memory request, held until mem_ack`
- `mem_we  out  1  memory write enable`
- `mem_addr  out  ADDR_WIDTH  memory address`
- `mem_wdata  out  DATA_WIDTH  memory write data`
- `mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack`
- `mem_ack  in  1  memory completion, one-cycle pulse`

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY. Reset state IDLE.
- IDLE: neither req → stay. Only one req → grant it. Both → grant DM unless `starve_cnt == STARVE_LIMIT`, then grant IF.
- Grant: register address/we/wdata into `mem_*`, assert `mem_req`; for IF grant `mem_we = 0`.
- *_BUSY: hold `mem_*` stable; on `mem_ack` capture `mem_rdata` into the granted port's rdata register (loads and fetches only), pulse that port's ready, go IDLE. No ack → stay indefinitely.
- `starve_cnt` (width ⌈log2(STARVE_LIMIT+1)⌉): +1 on each DM grant while `if_req` high; cleared on IF grant or when granting DM with `if_req` low; saturates at STARVE_LIMIT.
- `dm_rdata` unchanged on store completion; `if_rdata`/`dm_rdata` hold last value between completions.
- Requester must drop or change its request the cycle after ready; a req still high in IDLE is a new request.
- Inputs sampled only in IDLE; changes during BUSY are ignored.

## Timing
- Reset values: `mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, starve_cnt=0`. All outputs registered.
- Reset mid-transaction: `mem_req` drops asynchronously, FSM to IDLE, no ready pulse; memory must tolerate abandoned request; late `mem_ack` in IDLE ignored.
- Req seen at edge k → `mem_req` high in cycle k+1. `mem_ack` may arrive in that same cycle (zero-wait memory).
- Ack in cycle n → ready pulse and rdata in cycle n+1, FSM IDLE in n+1.
- Zero-wait memory: request-to-ready 2 cycles; one transaction per 2 cycles (IDLE slot between transactions).
- Simultaneous requests in IDLE resolved in one cycle by priority rule above; losing request waits, stays high.

## Structure
- Shared package `pipeline_mem_arb_pkg`: state encoding (IDLE=2'd0, IF_BUSY=2'd1, DM_BUSY=2'd2), grant-select constants, default widths.
- One natural sub-module: `mem_arb_starve_ctr` (saturating counter + limit compare producing `force_if`). FSM and datapath registers in top.

## Test plan
- IF only, `if_addr=0x0000_0004`, zero-wait memory returning 0x00A6_2023 → `mem_req` next cycle, `if_ready` pulse 2 cycles after req, `if_rdata=0x00A6_2023`.
- Store then load: `dm_we=1, dm_addr=0x8, dm_wdata=0x0000_000E`, then `dm_we=0, dm_addr=0x8` → `mem_we=1` then 0; `dm_rdata=0x0000_000E`; `dm_rdata` unchanged after store.
- Both req every cycle, STARVE_LIMIT=4 → grant order DM,DM,DM,DM,IF, repeating; IF never waits more than 5 transactions.
- Memory acking 3 cycles after `mem_req` → `mem_addr/mem_we/mem_wdata` stable throughout; ready 1 cycle after ack; other request not granted early.
- Async reset asserted while DM_BUSY → `mem_req`=0 immediately, no `dm_ready`; after release, stale `mem_ack` in IDLE produces no ready.
- Reset values: hold `reset=0` for 2 cycles → all outputs 0, first request after release serviced normally.

Source files
------------

// File: rtl/pipeline_mem_arb_pkg.sv
// Shared definitions for the IF/DM unified-memory arbiter.
package pipeline_mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 32;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } arb_grant_e;

endpackage

// File: rtl/pipeline_mem_arbiter_starve_ctr.sv
// Saturating count of DM grants taken while IF was waiting; flags when IF must win.
module mem_arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_grant_dm,
    input  logic i_grant_if,
    input  logic i_if_req,
    output logic o_force_if
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_grant_if || (i_grant_dm && !i_if_req)) begin
            r_cnt <= '0;
        end else if (i_grant_dm && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_force_if = (r_cnt == LIMIT);

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates IF and DM ports onto one single-port memory, one transaction at a time,
// DM first unless IF has been passed over STARVE_LIMIT times in a row.
module pipeline_mem_arbiter
    import pipeline_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    arb_grant_e w_grant;
    logic       w_force_if;
    logic       w_done;

    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_if_ready;
    logic                  r_dm_ready;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clock      (clock),
        .reset      (reset),
        .i_grant_dm (w_grant == GNT_DM),
        .i_grant_if (w_grant == GNT_IF),
        .i_if_req   (if_req),
        .o_force_if (w_force_if)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_grant     = GNT_NONE;
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dm_req && !(if_req && w_force_if)) begin
                    w_grant     = GNT_DM;
                    w_state_nxt = ST_DM_BUSY;
                end else if (if_req) begin
                    w_grant     = GNT_IF;
                    w_state_nxt = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY, ST_DM_BUSY: begin
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Ack is only honoured while busy, so a late ack after reset falls through.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            case (w_grant)
                GNT_IF: begin
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= if_addr;
                end
                GNT_DM: begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= dm_we;
                    r_mem_addr  <= dm_addr;
                    r_mem_wdata <= dm_wdata;
                end
                default: ;
            endcase
            if (w_done) begin
                r_mem_req <= 1'b0;
                if (r_state == ST_IF_BUSY) begin
                    r_if_ready <= 1'b1;
                    r_if_rdata <= mem_rdata;
                end else begin
                    r_dm_ready <= 1'b1;
                    if (!r_mem_we) begin
                        r_dm_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Scoreboard bench for pipeline_mem_arbiter with a variable-latency memory model.
module tb_pipeline_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_arr [16];
    logic [31:0] ref_mem [16];
    int unsigned lat = 0;
    int unsigned wc = 0;
    logic        stale_ack = 1'b0;

    logic [31:0] if_q [$];
    logic [31:0] dm_q [$];
    int          grant_q [$];
    bit          chk_grant = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] exp_dm_last = '0;

    always #5 clock = ~clock;

    pipeline_mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Memory: acks after 'lat' extra cycles of mem_req; lat=0 acks in the request's first cycle.
    assign mem_ack   = (mem_req && (wc == lat)) || stale_ack;
    assign mem_rdata = mem_arr[mem_addr[5:2]];

    always @(posedge clock) begin
        if (mem_req && mem_ack && mem_we) mem_arr[mem_addr[5:2]] <= mem_wdata;
        if (mem_req && !mem_ack) wc <= wc + 1;
        else wc <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (if_ready) begin
                if (if_q.size() == 0) chk("if_unexpected_ready", 32'd1, 32'd0);
                else chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (dm_ready) begin
                if (dm_q.size() == 0) chk("dm_unexpected_ready", 32'd1, 32'd0);
                else chk("dm_rdata", dm_rdata, dm_q.pop_front());
            end
            if (chk_grant && mem_req && !prev_req && grant_q.size() > 0)
                chk("grant_order", (mem_addr >= 32'h20) ? 32'd1 : 32'd0, grant_q.pop_front());
            prev_req <= mem_req;
        end
    end

    task automatic do_if(input logic [31:0] a, input bit keep, input int exp_lat);
        int n = 0;
        if_req  = 1'b1;
        if_addr = a;
        if_q.push_back(ref_mem[a[5:2]]);
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == 1 && exp_lat > 0) begin
                chk("if_mem_req", mem_req, 1'b1);
                chk("if_mem_we", mem_we, 1'b0);
            end
        end while (!if_ready && n < 80);
        if (!if_ready) chk("if_timeout", 32'd0, 32'd1);
        else if (exp_lat > 0) chk("if_latency", n, exp_lat);
        if (!keep) if_req = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input bit keep, input int exp_lat);
        int n = 0;
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        if (we) ref_mem[a[5:2]] = wd;
        else exp_dm_last = ref_mem[a[5:2]];
        dm_q.push_back(exp_dm_last);
        do begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == 1 && exp_lat > 0) begin
                chk("dm_mem_req", mem_req, 1'b1);
                chk("dm_mem_we", mem_we, we);
            end
        end while (!dm_ready && n < 80);
        if (!dm_ready) chk("dm_timeout", 32'd0, 32'd1);
        else if (exp_lat > 0) chk("dm_latency", n, exp_lat);
        if (!keep) dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = 32'h5A00_0000 | (i * 32'h0101);
            if (i == 1) mem_arr[i] = 32'h00A6_2023;
            ref_mem[i] = mem_arr[i];
        end

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_ready", if_ready, 1'b0);
        chk("rst_dm_ready", dm_ready, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        reset = 1'b1;
        @(negedge clock);

        // IF only, zero-wait
        do_if(32'h0000_0004, 1'b0, 2);
        @(negedge clock);

        // Store, load back, then a store that must leave dm_rdata alone
        do_dm(1'b1, 32'h8, 32'h0000_000E, 1'b0, 2);
        do_dm(1'b0, 32'h8, 32'h0, 1'b0, 2);
        do_dm(1'b1, 32'hC, 32'h0000_1234, 1'b0, 2);
        @(negedge clock);
        chk("dm_rdata_hold", dm_rdata, 32'h0000_000E);

        // Slow memory: DM store held stable for 4 cycles while IF waits
        lat = 3;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h24; dm_wdata = 32'hCAFE_0024;
        ref_mem[9] = 32'hCAFE_0024;
        dm_q.push_back(exp_dm_last);
        if_req = 1'b1; if_addr = 32'h10;
        if_q.push_back(ref_mem[4]);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            chk("slow_mem_req", mem_req, 1'b1);
            chk("slow_mem_addr", mem_addr, 32'h24);
            chk("slow_mem_we", mem_we, 1'b1);
            chk("slow_mem_wdata", mem_wdata, 32'hCAFE_0024);
            chk("slow_if_ready", if_ready, 1'b0);
            chk("slow_dm_ready", dm_ready, 1'b0);
        end
        @(negedge clock);
        chk("slow_dm_ready_after_ack", dm_ready, 1'b1);
        chk("slow_mem_req_drop", mem_req, 1'b0);
        dm_req = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clock);
                n++;
                if (n == 1) chk("slow_if_grant_addr", mem_addr, 32'h10);
            end while (!if_ready && n < 40);
            chk("slow_if_latency", n, 5);
        end
        if_req = 1'b0;
        lat = 0;
        @(negedge clock);
        chk("slow_mem_stored", mem_arr[9], 32'hCAFE_0024);

        // Starvation guard: both request continuously
        for (int g = 0; g < 10; g++) grant_q.push_back((g % 5 == 4) ? 0 : 1);
        chk_grant = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) do_dm(1'b0, 32'h20 + 4 * i, 32'h0, (i < 7), 0);
            end
            begin
                for (int j = 0; j < 2; j++) do_if(4 * j, (j < 1), 0);
            end
        join
        chk_grant = 1'b0;
        chk("grant_all_seen", grant_q.size(), 0);
        @(negedge clock);

        // Reset during DM_BUSY, then a stale ack in IDLE
        lat = 6;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h28;
        repeat (2) @(negedge clock);
        chk("midrst_busy", mem_req, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_async_mem_req", mem_req, 1'b0);
        dm_req = 1'b0;
        repeat (2) @(negedge clock);
        chk("midrst_no_dm_ready", dm_ready, 1'b0);
        reset = 1'b1;
        lat = 0;
        exp_dm_last = '0;
        @(negedge clock);
        stale_ack = 1'b1;
        @(negedge clock);
        stale_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk("stale_dm_ready", dm_ready, 1'b0);
            chk("stale_if_ready", if_ready, 1'b0);
            chk("stale_mem_req", mem_req, 1'b0);
        end

        // Normal service after reset
        do_dm(1'b0, 32'h28, 32'h0, 1'b0, 2);
        do_if(32'h8, 1'b0, 2);
        repeat (2) @(negedge clock);

        chk("if_queue_empty", if_q.size(), 0);
        chk("dm_queue_empty", dm_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
